traffic_countdown_display: RTL and testbench

//   Downstream consumer of traffic_light_controller: samples its R/G lamp outputs, tracks
//   the active phase and drives a 2-digit multiplexed 7-segment countdown of whole seconds

---
 rtl/traffic_pkg.sv | 36 +++
 rtl/traffic_countdown_display_seg7.sv | 22 ++
 rtl/traffic_countdown_display.sv | 124 ++++++++++++
 tb/tb_traffic_countdown_display.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_pkg : shared phase encodings, segment constants and BCD helper     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_OFF   = 2'd0,
    PH_RED   = 2'd1,
    PH_GREEN = 2'd2,
    PH_FAULT = 2'd3
  } phase_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; element [n] is the glyph for digit n (0..F).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [7:0] to_bcd8(input int value);
    int v;
    v = (value < 0) ? 0 : ((value > 99) ? 99 : value);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // {G,R} lines up directly with the phase encoding: R alone=RED, G alone=GREEN.
  function automatic phase_e decode_phase(input logic r, input logic g);
    return phase_e'({g, r});
  endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_countdown_display_seg7.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seg7_decode : 4-bit digit plus blank control to active-low 7-seg pattern   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module seg7_decode
  import traffic_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_TABLE[digit_i];
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end
  end

endmodule
`default_nettype wire

// File: rtl/traffic_countdown_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | traffic_countdown_display : tracks controller phase from R/G lamps and     |
// | drives a 2-digit multiplexed 7-seg countdown of seconds left in the phase  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module traffic_countdown_display
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter int RED_SECS   = 30,
  parameter int GREEN_SECS = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       R,
  input  logic       G,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic [1:0] phase,
  output logic [7:0] remaining,
  output logic       fault,
  output logic       fault_seen
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int SCAN_W = $clog2(SCAN_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [7:0] RED_BCD   = to_bcd8(RED_SECS);
  localparam logic [7:0] GREEN_BCD = to_bcd8(GREEN_SECS);

  phase_e            phase_q, phase_d;
  logic [7:0]        rem_q, rem_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;
  logic              fault_seen_q, fault_seen_d;

  phase_e     ph_in;
  logic       ph_change;
  logic       tick_wrap;
  logic       scan_wrap;
  logic [3:0] dec_digit;
  logic       dec_blank;
  logic [6:0] dec_seg;

  assign ph_in     = decode_phase(R, G);
  assign ph_change = (ph_in != phase_q);
  assign tick_wrap = (tick_q == TICK_LAST);
  assign scan_wrap = (scan_q == SCAN_LAST);

  // sel_q=0 selects units, 1 selects tens; tens gets leading-zero blanking.
  assign dec_digit = sel_q ? rem_q[7:4] : rem_q[3:0];
  assign dec_blank = (phase_q == PH_OFF) || (sel_q && (rem_q[7:4] == 4'd0));

  seg7_decode u_seg7 (
    .digit_i (dec_digit),
    .blank_i (dec_blank),
    .seg_o   (dec_seg)
  );

  always_comb begin
    phase_d      = phase_q;
    rem_d        = rem_q;
    tick_d       = tick_wrap ? '0 : tick_q + TICK_W'(1);
    scan_d       = scan_wrap ? '0 : scan_q + SCAN_W'(1);
    sel_d        = sel_q ^ scan_wrap;
    fault_seen_d = fault_seen_q | (ph_in == PH_FAULT);
    an_d         = sel_q ? 2'b01 : 2'b10;
    seg_d        = (phase_q == PH_FAULT) ? SEG_DASH : dec_seg;

    // A phase load wins over a coincident tick and restarts the second.
    if (ph_change) begin
      phase_d = ph_in;
      tick_d  = '0;
      case (ph_in)
        PH_RED:   rem_d = RED_BCD;
        PH_GREEN: rem_d = GREEN_BCD;
        default:  rem_d = 8'h00;
      endcase
    end else if (tick_wrap && (rem_q != 8'h00)) begin
      if (rem_q[3:0] == 4'd0) begin
        rem_d = {rem_q[7:4] - 4'd1, 4'd9};
      end else begin
        rem_d = {rem_q[7:4], rem_q[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q      <= PH_OFF;
      rem_q        <= 8'h00;
      tick_q       <= '0;
      scan_q       <= '0;
      sel_q        <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= 2'b11;
      fault_seen_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      rem_q        <= rem_d;
      tick_q       <= tick_d;
      scan_q       <= scan_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      fault_seen_q <= fault_seen_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign phase      = phase_q;
  assign remaining  = rem_q;
  assign fault      = (phase_q == PH_FAULT);
  assign fault_seen = fault_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_countdown_display.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_traffic_countdown_display : directed vector bench for the countdown     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_traffic_countdown_display;

  logic       clk;
  logic       reset;
  logic       R;
  logic       G;
  logic [6:0] seg;
  logic [1:0] an;
  logic [1:0] phase;
  logic [7:0] remaining;
  logic       fault;
  logic       fault_seen;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_countdown_display #(
    .TICK_DIV   (10),
    .SCAN_DIV   (4),
    .RED_SECS   (12),
    .GREEN_SECS (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .R          (R),
    .G          (G),
    .seg        (seg),
    .an         (an),
    .phase      (phase),
    .remaining  (remaining),
    .fault      (fault),
    .fault_seen (fault_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       g;
    int         cycles;
    logic [1:0] ph;
    logic [7:0] rem;
    logic       flt;
    logic       fs;
    logic       chk;
    logic [6:0] useg;
    logic [6:0] tseg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic g, input int cyc, input logic [1:0] ph,
                     input logic [7:0] rem, input logic flt, input logic fs,
                     input logic chk, input logic [6:0] useg, input logic [6:0] tseg);
    vec_t v;
    v.r = r; v.g = g; v.cycles = cyc; v.ph = ph; v.rem = rem;
    v.flt = flt; v.fs = fs; v.chk = chk; v.useg = useg; v.tseg = tseg;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    R     = 1'b0;
    G     = 1'b0;

    //     R  G  cyc ph  rem    flt fs  chk useg   tseg
    add(0, 0,  5, 0, 8'h00, 0, 0, 1, 7'h7F, 7'h7F); // OFF: blank, still scanning
    add(1, 0,  1, 1, 8'h12, 0, 0, 0, 7'h00, 7'h00); // load RED
    add(1, 0,  9, 1, 8'h12, 0, 0, 1, 7'h24, 7'h79); // full first second, "12"
    add(1, 0,  1, 1, 8'h11, 0, 0, 0, 7'h00, 7'h00);
    add(1, 0, 10, 1, 8'h10, 0, 0, 0, 7'h00, 7'h00);
    add(1, 0, 10, 1, 8'h09, 0, 0, 0, 7'h00, 7'h00); // BCD borrow
    add(1, 0,  9, 1, 8'h09, 0, 0, 1, 7'h10, 7'h7F); // tens blanked
    add(1, 0, 81, 1, 8'h00, 0, 0, 0, 7'h00, 7'h00); // 120 cycles after load
    add(1, 0, 30, 1, 8'h00, 0, 0, 1, 7'h40, 7'h7F); // holds at 00
    add(1, 0,  9, 1, 8'h00, 0, 0, 0, 7'h00, 7'h00); // tick counter now at last count
    add(0, 1,  1, 2, 8'h08, 0, 0, 0, 7'h00, 7'h00); // load coincides with tick wrap
    add(0, 1,  9, 2, 8'h08, 0, 0, 1, 7'h00, 7'h7F);
    add(0, 1,  1, 2, 8'h07, 0, 0, 0, 7'h00, 7'h00);
    add(1, 1,  1, 3, 8'h00, 1, 1, 0, 7'h00, 7'h00); // one-cycle FAULT
    add(0, 1,  1, 2, 8'h08, 0, 1, 1, 7'h3F, 7'h3F); // dash shown, sticky flag kept
    add(0, 1, 30, 2, 8'h05, 0, 1, 0, 7'h00, 7'h00);

    for (int k = 0; k < 3; k++) step();
    chk("reset seg",        {1'b0, seg},        8'h7F);
    chk("reset an",         {6'd0, an},         8'h03);
    chk("reset phase",      {6'd0, phase},      8'h00);
    chk("reset remaining",  remaining,          8'h00);
    chk("reset fault",      {7'd0, fault},      8'h00);
    chk("reset fault_seen", {7'd0, fault_seen}, 8'h00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      R = vecs[i].r;
      G = vecs[i].g;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        step();
        if (vecs[i].chk) begin
          if (an == 2'b10)
            chk($sformatf("v%0d units seg", i), {1'b0, seg}, {1'b0, vecs[i].useg});
          else if (an == 2'b01)
            chk($sformatf("v%0d tens seg", i), {1'b0, seg}, {1'b0, vecs[i].tseg});
          else
            chk($sformatf("v%0d an one-hot-low", i), {6'd0, an}, 8'h02);
        end
      end
      chk($sformatf("v%0d phase", i),      {6'd0, phase},      {6'd0, vecs[i].ph});
      chk($sformatf("v%0d remaining", i),  remaining,          vecs[i].rem);
      chk($sformatf("v%0d fault", i),      {7'd0, fault},      {7'd0, vecs[i].flt});
      chk($sformatf("v%0d fault_seen", i), {7'd0, fault_seen}, {7'd0, vecs[i].fs});
    end

    // Asynchronous reset between clock edges while counting at 05.
    #2;
    reset = 1'b1;
    #1;
    chk("async seg",        {1'b0, seg},        8'h7F);
    chk("async an",         {6'd0, an},         8'h03);
    chk("async phase",      {6'd0, phase},      8'h00);
    chk("async remaining",  remaining,          8'h00);
    chk("async fault",      {7'd0, fault},      8'h00);
    chk("async fault_seen", {7'd0, fault_seen}, 8'h00);
    #1;
    reset = 1'b0;

    step();
    chk("post-reset phase",     {6'd0, phase}, 8'h02);
    chk("post-reset remaining", remaining,     8'h08);
    chk("post-reset an units",  {6'd0, an},    8'h02);
    chk("post-reset seg blank", {1'b0, seg},   8'h7F);
    step();
    chk("post-reset an hold",   {6'd0, an},    8'h02);
    chk("post-reset seg 8",     {1'b0, seg},   8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
